// File: rtl/aes_decryption.sv
// Iterative AES-128 inverse cipher: start latches key/ciphertext, 10 key-expansion cycles then 10 inverse rounds.
// done pulses 20 clocks after the start-sampling edge; start is ignored while busy (no queueing).
module aes_decryption #(
  parameter int NR = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] c_key,
  output logic         busy,
  output logic         done,
  output logic [127:0] dataout
);

  localparam logic [3:0] LAST_RK   = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  // Tables are stored entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, KEXP, ROUND} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte k lives at [8*(15-k) +: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c-r+4)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      o[8*(14-4*c) +: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      o[8*(13-4*c) +: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      o[8*(12-4*c) +: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
    return o;
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   cnt;
  logic [127:0] rk [0:NR];
  logic [127:0] st;
  logic [127:0] ct;
  logic [127:0] rk_new;
  logic [127:0] round_pre;
  logic [127:0] round_out;

  always_comb begin
    rk_new    = key_step(rk[cnt - 4'd1], rcon(cnt));
    round_pre = inv_sub_bytes(inv_shift_rows(st)) ^ rk[cnt];
    round_out = inv_mix_columns(round_pre);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = KEXP;
      KEXP:    if (cnt == LAST_RK) state_nxt = ROUND;
      ROUND:   if (cnt == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      dataout <= '0;
      cnt     <= '0;
      st      <= '0;
      ct      <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ct    <= cipher_text;
            rk[0] <= c_key;
            cnt   <= 4'd1;
            busy  <= 1'b1;
          end
        end
        KEXP: begin
          rk[cnt] <= rk_new;
          if (cnt == LAST_RK) begin
            // First AddRoundKey uses the key being written this edge.
            st  <= ct ^ rk_new;
            cnt <= FIRST_RND;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          if (cnt == 4'd0) begin
            dataout <= round_pre;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            st  <= round_out;
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_decryption.md
Name: aes_decryption

Overview:
- Iterative AES-128 inverse cipher (FIPS-197), the decrypt counterpart of the AES_encryption core.
- Accepts a 128-bit ciphertext and cipher key on a start pulse. Expands the key schedule internally, then runs one inverse round per clock.
- Returns the plaintext with a one-cycle done pulse.
- Sits beside the encryption core so the same key/data buses can be looped back for round-trip checks.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, other values unsupported.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- cipher_text  input  128  ciphertext; [127:120] = byte 0 (FIPS hex-string order)
- c_key  input  128  cipher key, same byte order
- busy  output  1  high while a block is in progress
- done  output  1  one-cycle pulse when dataout is updated
- dataout  output  128  recovered plaintext; holds until the next completion

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, dataout=0; counters, key store and state register cleared.
- Registers: rk[0..10] (11x128 key store), st (128 state), ct (latched ciphertext), cnt (4-bit).
- IDLE:
  - busy=0.
  - start=1 at a rising edge (E0): ct<=cipher_text, rk[0]<=c_key, cnt<=1, go KEXP.
  - start=0: stay in IDLE.
- KEXP (edges E1..E10):
  - rk[cnt] <= standard expansion of rk[cnt-1]: RotWord, SubWord, Rcon[cnt] = 01,02,04,08,10,20,40,80,1b,36.
  - cnt++.
  - On E10 (cnt=10): also st <= ct ^ rk10_next, where rk10_next is the value being written to rk[10]. Then cnt<=9, go ROUND.
- ROUND (edges E11..E20):
  - cnt 9..1: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[cnt]); cnt--.
  - cnt=0 (E20): dataout <= InvSubBytes(InvShiftRows(st)) ^ rk[0]; done<=1; busy<=0; go IDLE.
- Latency: done is high in the cycle after E20, i.e. 20 clocks after the start-sampling edge. Throughput is one block per 21 cycles.
- busy: 1 from after E0 through the cycle containing E20; 0 when done=1.
- done: exactly one cycle wide; cleared on the next edge.
- start while busy: ignored; no queueing, no effect on the in-flight block.
- start=1 in the done cycle: state is IDLE, so it is accepted. Back-to-back blocks are legal.
- Inputs are latched at E0. cipher_text/c_key changes during busy have no effect.
- Reset mid-operation: immediate abort to IDLE with all outputs at reset values. No done pulse for the aborted block.
- InvSubBytes: inverse S-box, combinational table, 16 instances.
- InvMixColumns: GF(2^8) multiply by 0e,0b,0d,09 with polynomial 0x11b.
- Key expansion uses the forward S-box, 4 instances.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, one-cycle start -> done after exactly 20 clocks; dataout=00112233445566778899aabbccddeeff; busy high for exactly 20 cycles.
- Key 5468617473206D79204B756E67204675, ct 29c3505f571420f6402299b31a02d73a -> dataout=54776F204F6E65204E696E652054776F.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> dataout=3243f6a8885a308d313198a2e0370734.
- Back-to-back: start held high in the done cycle with the next vector, inputs changed mid-busy, and extra start pulses while busy -> two done pulses exactly 21 cycles apart, both correct. Mid-busy input changes and stray starts have no effect.
- Drop reset_n for 1 cycle at cycle 12 of a block -> busy/done/dataout immediately 0, no done pulse. A fresh start afterward yields a correct result.
- Loopback: AES_encryption output fed to this block with the same key, for 100 random key/plaintext pairs -> dataout equals the original plaintext for every pair.
